sm_rom_arbiter: RTL and testbench

- Round-robin arbiter that shares the single asynchronous instruction-ROM read port (word-indexed `a` in, `rd` out, same cycle) between N fetch requesters, e.g. multiple harts or hart + debug fetcher.
- Sits between the requesters' fetch interfaces and sm_rom.
- Returns registered read data one cycle after grant.
- Supports bounded bus locking for back-to-back fetches.
- Flags out-of-range word addresses.

---
 rtl/sm_rom_arbiter_if.sv | 23 ++
 rtl/sm_rom_arbiter.sv | 119 +++++++++++
 tb/tb_sm_rom_arbiter.sv | 172 +++++++++++++++++
 3 files changed

// File: rtl/sm_rom_arbiter_if.sv
// Fetch-side bus of the instruction-ROM arbiter: N requesters sharing one port.
// The master drives requests; the arbiter (slave) returns grants and read data.
interface sm_rom_arbiter_if #(
  parameter int N = 2
);
  logic [N-1:0]    req;
  logic [N-1:0]    lock;
  logic [32*N-1:0] addr;
  logic [N-1:0]    gnt;
  logic [N-1:0]    rvalid;
  logic [31:0]     rdata;
  logic            err;

  modport master (
    output req, lock, addr,
    input  gnt, rvalid, rdata, err
  );

  modport slave (
    input  req, lock, addr,
    output gnt, rvalid, rdata, err
  );
endinterface

// File: rtl/sm_rom_arbiter.sv
// Round-robin arbiter sharing the asynchronous sm_rom read port between N fetchers,
// with bounded lock runs and out-of-range address flagging.
module sm_rom_arbiter #(
  parameter int N        = 2,
  parameter int SIZE     = 64,
  parameter int MAX_LOCK = 4
) (
  input  logic                clk,
  input  logic                rst,
  sm_rom_arbiter_if.slave     bus,
  output logic [31:0]         rom_a,
  input  logic [31:0]         rom_rd
);
  localparam int PW = (N > 1) ? $clog2(N) : 1;
  localparam int CW = 4;

  logic [PW-1:0] rr_ptr_r;
  logic [PW-1:0] owner_r;
  logic          owner_vld_r;
  logic [CW-1:0] lock_cnt_r;
  logic [N-1:0]  rvalid_r;
  logic [31:0]   rdata_r;
  logic          err_r;

  logic          lock_hit_s;
  logic [PW:0]   pick_s;
  logic          win_vld_s;
  logic [PW-1:0] win_s;
  logic [31:0]   win_addr_s;
  logic          in_range_s;
  logic [N-1:0]  gnt_s;
  logic [31:0]   rom_a_s;

  // First requester at or after ptr (wrapping); MSB of the result flags "found".
  function automatic logic [PW:0] rr_pick(input logic [N-1:0] r, input logic [PW-1:0] ptr);
    logic [PW:0] res;
    int          idx;
    res = '0;
    for (int k = 0; k < N; k++) begin
      idx = (int'(ptr) + k) % N;
      res = (!res[PW] && r[idx]) ? {1'b1, PW'(idx)} : res;
    end
    return res;
  endfunction

  // Winner selection: an unexpired lock run beats the round-robin search.
  always_comb begin
    lock_hit_s = owner_vld_r && bus.req[owner_r] && bus.lock[owner_r] &&
                 (lock_cnt_r < CW'(MAX_LOCK));
    pick_s     = rr_pick(bus.req, rr_ptr_r);
    if (lock_hit_s) begin
      win_vld_s = 1'b1;
      win_s     = owner_r;
    end else begin
      win_vld_s = pick_s[PW];
      win_s     = pick_s[PW-1:0];
    end
  end

  // Grant and ROM address; both are forced low while reset is asserted.
  always_comb begin
    gnt_s      = '0;
    rom_a_s    = 32'h0000_0000;
    win_addr_s = bus.addr[{win_s, 5'b00000} +: 32];
    in_range_s = (win_addr_s < 32'(SIZE));
    if (!rst && win_vld_s) begin
      gnt_s[win_s] = 1'b1;
      rom_a_s      = win_addr_s;
    end else begin
      gnt_s   = '0;
      rom_a_s = 32'h0000_0000;
    end
  end

  // Response registers, round-robin pointer and lock-run bookkeeping.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      rr_ptr_r    <= '0;
      owner_r     <= '0;
      owner_vld_r <= 1'b0;
      lock_cnt_r  <= '0;
      rvalid_r    <= '0;
      rdata_r     <= 32'h0000_0000;
      err_r       <= 1'b0;
    end else if (win_vld_s) begin
      rvalid_r <= gnt_s;
      rdata_r  <= in_range_s ? rom_rd : 32'h0000_0000;
      err_r    <= !in_range_s;
      rr_ptr_r <= (win_s == PW'(N - 1)) ? '0 : (win_s + PW'(1));
      if (bus.lock[win_s]) begin
        // Re-granting an expired owner through round-robin starts a fresh run.
        if (lock_hit_s) begin
          lock_cnt_r <= lock_cnt_r + CW'(1);
        end else begin
          owner_r     <= win_s;
          owner_vld_r <= 1'b1;
          lock_cnt_r  <= CW'(1);
        end
      end else begin
        owner_r     <= '0;
        owner_vld_r <= 1'b0;
        lock_cnt_r  <= '0;
      end
    end else begin
      rvalid_r    <= '0;
      err_r       <= 1'b0;
      owner_r     <= '0;
      owner_vld_r <= 1'b0;
      lock_cnt_r  <= '0;
    end
  end

  assign bus.gnt    = gnt_s;
  assign bus.rvalid = rvalid_r;
  assign bus.rdata  = rdata_r;
  assign bus.err    = err_r;
  assign rom_a      = rom_a_s;

endmodule

// File: tb/tb_sm_rom_arbiter.sv
// Bench for sm_rom_arbiter (N=3): directed scenarios then random traffic,
// all checked against a behavioural arbitration model.
module tb_sm_rom_arbiter;
  localparam int N        = 3;
  localparam int SIZE     = 64;
  localparam int MAX_LOCK = 4;

  logic        clk;
  logic        rst;
  logic [31:0] rom_a;
  logic [31:0] rom_rd;
  logic [31:0] rom [0:SIZE-1];

  sm_rom_arbiter_if #(.N(N)) bus ();

  sm_rom_arbiter #(.N(N), .SIZE(SIZE), .MAX_LOCK(MAX_LOCK)) dut (
    .clk    (clk),
    .rst    (rst),
    .bus    (bus),
    .rom_a  (rom_a),
    .rom_rd (rom_rd)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // ROM model; out-of-range reads return junk the arbiter must not pass on.
  always_comb rom_rd = (rom_a < 32'(SIZE)) ? rom[rom_a[5:0]] : 32'hdead_beef;

  int total = 0;
  int bad   = 0;

  // Reference state: -1 means no owner.
  int          m_rr;
  int          m_owner;
  int          m_cnt;
  logic [31:0] e_rdata;
  logic [31:0] e_rvalid;
  logic [31:0] e_err;
  logic [2:0]  obs_gnt;
  logic [2:0]  gseq [0:8];

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    total++;
    assert (got === exp) else begin
      bad++;
      $error("FAIL %s: observed=%h expected=%h", tag, got, exp);
    end
  endtask

  task automatic model_reset();
    m_rr = 0; m_owner = -1; m_cnt = 0;
    e_rdata = 32'd0; e_rvalid = 32'd0; e_err = 32'd0;
  endtask

  // One cycle: drive, check grant, advance the model across the edge, check response.
  task automatic step(input logic [2:0] r, input logic [2:0] l,
                      input logic [31:0] a0, input logic [31:0] a1, input logic [31:0] a2);
    logic [31:0] am [0:2];
    int w;
    am[0] = a0; am[1] = a1; am[2] = a2;
    bus.req = r; bus.lock = l; bus.addr = {a2, a1, a0};
    #1;
    w = -1;
    if (m_owner >= 0 && r[m_owner] && l[m_owner] && m_cnt < MAX_LOCK) w = m_owner;
    else for (int k = 0; k < N; k++) if (w < 0 && r[(m_rr + k) % N]) w = (m_rr + k) % N;
    obs_gnt = bus.gnt;
    chk("gnt", {29'd0, bus.gnt}, (w < 0) ? 32'd0 : (32'd1 << w));
    chk("rom_a", rom_a, (w < 0) ? 32'd0 : am[w]);
    if (w >= 0) begin
      e_rvalid = 32'd1 << w;
      e_err    = (am[w] >= SIZE) ? 32'd1 : 32'd0;
      e_rdata  = (am[w] >= SIZE) ? 32'd0 : rom[am[w][5:0]];
      m_rr     = (w + 1) % N;
      if (l[w]) begin
        if (w == m_owner && m_cnt < MAX_LOCK) m_cnt++;
        else begin m_owner = w; m_cnt = 1; end
      end else begin m_owner = -1; m_cnt = 0; end
    end else begin
      e_rvalid = 32'd0; e_err = 32'd0; m_owner = -1; m_cnt = 0;
    end
    @(posedge clk);
    @(negedge clk);
    chk("rvalid", {29'd0, bus.rvalid}, e_rvalid);
    chk("rdata", bus.rdata, e_rdata);
    chk("err", {31'd0, bus.err}, e_err);
  endtask

  function automatic logic [31:0] rnd_addr();
    case ($urandom_range(0, 9))
      0:       rnd_addr = 32'h8000_0000 | 32'($urandom_range(0, 63));
      1:       rnd_addr = 32'd64;
      2:       rnd_addr = 32'd63;
      default: rnd_addr = 32'($urandom_range(0, 63));
    endcase
  endfunction

  initial begin
    for (int i = 0; i < SIZE; i++) rom[i] = $urandom;
    rom[5] = 32'h0050_0093;
    model_reset();
    rst = 1'b1;
    bus.req = 3'b111; bus.lock = 3'b000; bus.addr = {32'd3, 32'd2, 32'd1};
    repeat (2) @(negedge clk);
    chk("rst_gnt", {29'd0, bus.gnt}, 32'd0);
    chk("rst_rom_a", rom_a, 32'd0);
    chk("rst_rvalid", {29'd0, bus.rvalid}, 32'd0);
    chk("rst_rdata", bus.rdata, 32'd0);
    chk("rst_err", {31'd0, bus.err}, 32'd0);
    bus.req = 3'b000;
    rst = 1'b0;

    // Basic fetch with one-cycle data latency.
    step(3'b001, 3'b000, 32'd5, 32'd0, 32'd0);
    chk("t1_gnt", {29'd0, obs_gnt}, 32'd1);
    chk("t1_rdata", bus.rdata, 32'h0050_0093);

    // Plain alternation between two requesters.
    step(3'b010, 3'b000, 32'd0, 32'd9, 32'd0);
    for (int i = 0; i < 4; i++) begin
      step(3'b011, 3'b000, 32'd1, 32'd2, 32'd0);
      chk("t2_gnt", {29'd0, obs_gnt}, (i % 2 == 0) ? 32'd1 : 32'd2);
      chk("t2_rdata", bus.rdata, (i % 2 == 0) ? rom[1] : rom[2]);
    end

    // Lock run bounded to MAX_LOCK grants.
    for (int i = 0; i < 9; i++) begin
      step(3'b011, 3'b001, 32'd10, 32'd11, 32'd0);
      gseq[i] = obs_gnt;
    end
    for (int i = 0; i < 9; i++) chk("t3_gnt", {29'd0, gseq[i]}, (i == 4) ? 32'd2 : 32'd1);

    // Out-of-range address, then the last valid word.
    step(3'b001, 3'b000, 32'd64, 32'd0, 32'd0);
    chk("t4_err", {31'd0, bus.err}, 32'd1);
    chk("t4_rdata", bus.rdata, 32'd0);
    step(3'b001, 3'b000, 32'd63, 32'd0, 32'd0);
    chk("t4_err63", {31'd0, bus.err}, 32'd0);
    chk("t4_rdata63", bus.rdata, rom[63]);

    // Wrap across a non-power-of-two requester count (rr_ptr is 1 here).
    step(3'b000, 3'b000, 32'd0, 32'd0, 32'd0);
    step(3'b101, 3'b000, 32'd20, 32'd0, 32'd21);
    chk("t5_gnt_a", {29'd0, obs_gnt}, 32'd4);
    step(3'b101, 3'b000, 32'd20, 32'd0, 32'd21);
    chk("t5_gnt_b", {29'd0, obs_gnt}, 32'd1);
    step(3'b110, 3'b000, 32'd0, 32'd22, 32'd23);
    chk("t5_ptr", {29'd0, obs_gnt}, 32'd2);

    // Async reset between grant and the next edge.
    step(3'b001, 3'b000, 32'd5, 32'd0, 32'd0);
    bus.req = 3'b001; bus.addr = {32'd0, 32'd0, 32'd7};
    #1;
    rst = 1'b1;
    #1;
    chk("t6_rvalid", {29'd0, bus.rvalid}, 32'd0);
    chk("t6_rdata", bus.rdata, 32'd0);
    chk("t6_gnt", {29'd0, bus.gnt}, 32'd0);
    rst = 1'b0;
    model_reset();
    @(negedge clk);
    step(3'b001, 3'b000, 32'd7, 32'd0, 32'd0);
    chk("t6_after", bus.rdata, rom[7]);

    // Random traffic against the model.
    for (int i = 0; i < 400; i++)
      step(3'($urandom_range(0, 7)), 3'($urandom_range(0, 7)), rnd_addr(), rnd_addr(), rnd_addr());

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end
endmodule
